cs_sequencer: RTL and testbench

Next-address sequencer for the microprogrammed control unit. It selects the next control-store address each cycle from five sources: the incremented address, a jump target, an opcode decode map, a return stack, or a hold. It drives that address to the control-store address incrementer and holds the current micro-PC that addresses the control-store ROM. It is the producing end of the incrementer interface: it drives the address and the increment acknowledge, and it consumes the incrementer's registered CSAddress+1 output.

---
 rtl/cs_sequencer_pkg.sv | 26 ++
 rtl/cs_sequencer_if.sv | 36 +++
 rtl/cs_return_stack.sv | 42 ++++
 rtl/cs_sequencer.sv | 145 ++++++++++++++
 tb/tb_cs_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cs_sequencer_pkg.sv
// Shared encodings for the micro-sequencer: next-address select field, FSM states
// and the opcode decode-map shift.
package cs_sequencer_pkg;

  typedef enum logic [2:0] {
    SEL_CONT    = 3'd0,
    SEL_JUMP    = 3'd1,
    SEL_BRZ     = 3'd2,
    SEL_BRN     = 3'd3,
    SEL_DECODE  = 3'd4,
    SEL_CALL    = 3'd5,
    SEL_RET     = 3'd6,
    SEL_MEMWAIT = 3'd7
  } sel_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  // Each opcode owns four consecutive control-store words.
  localparam int unsigned DECODE_SHIFT = 2;

endpackage

// File: rtl/cs_sequencer_if.sv
// Bundle between the sequencer (master) and the control-store datapath: incrementer,
// microinstruction fields, flags, memory handshake and status outputs.
interface cs_sequencer_if #(
  parameter int unsigned CSAI_DATAWIDTH = 11,
  parameter int unsigned OPCODE_WIDTH   = 8
);
  logic [CSAI_DATAWIDTH-1:0] CS_SEQUENCER_CSAI_InBus;
  logic [2:0]                CS_SEQUENCER_SEL_InBus;
  logic [CSAI_DATAWIDTH-1:0] CS_SEQUENCER_JADDR_InBus;
  logic [OPCODE_WIDTH-1:0]   CS_SEQUENCER_OPCODE_InBus;
  logic                      CS_SEQUENCER_Z_InHigh;
  logic                      CS_SEQUENCER_N_InHigh;
  logic                      CS_SEQUENCER_MEMACK_InHigh;
  logic [CSAI_DATAWIDTH-1:0] CS_SEQUENCER_CSAddress_OutBus;
  logic [CSAI_DATAWIDTH-1:0] CS_SEQUENCER_uPC_OutBus;
  logic                      CS_SEQUENCER_ACK_OutHigh;
  logic                      CS_SEQUENCER_MEMREQ_OutHigh;
  logic                      CS_SEQUENCER_ERROR_OutHigh;
  logic                      CS_SEQUENCER_HALT_OutHigh;

  modport master (
    input  CS_SEQUENCER_CSAI_InBus, CS_SEQUENCER_SEL_InBus, CS_SEQUENCER_JADDR_InBus,
           CS_SEQUENCER_OPCODE_InBus, CS_SEQUENCER_Z_InHigh, CS_SEQUENCER_N_InHigh,
           CS_SEQUENCER_MEMACK_InHigh,
    output CS_SEQUENCER_CSAddress_OutBus, CS_SEQUENCER_uPC_OutBus, CS_SEQUENCER_ACK_OutHigh,
           CS_SEQUENCER_MEMREQ_OutHigh, CS_SEQUENCER_ERROR_OutHigh, CS_SEQUENCER_HALT_OutHigh
  );

  modport slave (
    output CS_SEQUENCER_CSAI_InBus, CS_SEQUENCER_SEL_InBus, CS_SEQUENCER_JADDR_InBus,
           CS_SEQUENCER_OPCODE_InBus, CS_SEQUENCER_Z_InHigh, CS_SEQUENCER_N_InHigh,
           CS_SEQUENCER_MEMACK_InHigh,
    input  CS_SEQUENCER_CSAddress_OutBus, CS_SEQUENCER_uPC_OutBus, CS_SEQUENCER_ACK_OutHigh,
           CS_SEQUENCER_MEMREQ_OutHigh, CS_SEQUENCER_ERROR_OutHigh, CS_SEQUENCER_HALT_OutHigh
  );
endinterface

// File: rtl/cs_return_stack.sv
// Micro-subroutine return-address LIFO; pushes when full and pops when empty are ignored.
module cs_return_stack #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      count_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top_idx;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign top_idx = count_q[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (push && !full) begin
      count_q <= count_q + (AW+1)'(1);
    end else if (pop && !empty) begin
      count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[count_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/cs_sequencer.sv
// Control-store next-address sequencer (BOOT/RUN/WAIT/HALT).
// Define CS_SEQUENCER_STACK_EN to enable the CALL/RET return stack and fault halting.
module cs_sequencer
  import cs_sequencer_pkg::*;
#(
  parameter int unsigned CSAI_DATAWIDTH = 11,
  parameter int unsigned OPCODE_WIDTH   = 8,
  parameter int unsigned STACK_DEPTH    = 4
) (
  input  logic          CS_SEQUENCER_CLOCK_50,
  input  logic          CS_SEQUENCER_RESET_InLow,
  cs_sequencer_if.master bus
);
  localparam int unsigned W = CSAI_DATAWIDTH;

  state_e         state_q, state_d;
  sel_e           sel;
  logic [W-1:0]   upc_q, addr, csai, jaddr, decode_addr;
  logic           ack, memreq, memack;

  assign sel         = sel_e'(bus.CS_SEQUENCER_SEL_InBus);
  assign csai        = bus.CS_SEQUENCER_CSAI_InBus;
  assign jaddr       = bus.CS_SEQUENCER_JADDR_InBus;
  assign memack      = bus.CS_SEQUENCER_MEMACK_InHigh;
  assign decode_addr = W'(bus.CS_SEQUENCER_OPCODE_InBus) << DECODE_SHIFT;

`ifdef CS_SEQUENCER_STACK_EN
  logic         push, pop, full, empty, fault, error_q;
  logic [W-1:0] top;

  cs_return_stack #(
    .WIDTH (W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (CS_SEQUENCER_CLOCK_50),
    .rst_n     (CS_SEQUENCER_RESET_InLow),
    .push      (push),
    .pop       (pop),
    .push_data (csai),
    .top       (top),
    .full      (full),
    .empty     (empty)
  );
`endif

  always_comb begin
    state_d = state_q;
    addr    = upc_q;
    ack     = 1'b0;
    memreq  = 1'b0;
`ifdef CS_SEQUENCER_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    fault   = 1'b0;
`endif
    unique case (state_q)
      ST_BOOT: begin
        addr    = '0;
        ack     = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        ack = 1'b1;
        unique case (sel)
          SEL_CONT:   addr = csai;
          SEL_JUMP:   addr = jaddr;
          SEL_BRZ:    addr = bus.CS_SEQUENCER_Z_InHigh ? jaddr : csai;
          SEL_BRN:    addr = bus.CS_SEQUENCER_N_InHigh ? jaddr : csai;
          SEL_DECODE: addr = decode_addr;
`ifdef CS_SEQUENCER_STACK_EN
          // A fault keeps addr at uPC so the ROM output freezes with the halt.
          SEL_CALL: begin
            if (full) begin
              fault   = 1'b1;
              state_d = ST_HALT;
            end else begin
              push = 1'b1;
              addr = jaddr;
            end
          end
          SEL_RET: begin
            if (empty) begin
              fault   = 1'b1;
              state_d = ST_HALT;
            end else begin
              pop  = 1'b1;
              addr = top;
            end
          end
`else
          SEL_CALL:   addr = jaddr;
          SEL_RET:    addr = csai;
`endif
          SEL_MEMWAIT: begin
            memreq = 1'b1;
            if (memack) begin
              addr = csai;
            end else begin
              state_d = ST_WAIT;
            end
          end
        endcase
      end
      ST_WAIT: begin
        ack    = 1'b1;
        memreq = 1'b1;
        if (memack) begin
          addr    = csai;
          state_d = ST_RUN;
        end
      end
      ST_HALT: ;
    endcase
  end

  always_ff @(posedge CS_SEQUENCER_CLOCK_50 or negedge CS_SEQUENCER_RESET_InLow) begin
    if (!CS_SEQUENCER_RESET_InLow) begin
      state_q <= ST_BOOT;
      upc_q   <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= addr;
    end
  end

`ifdef CS_SEQUENCER_STACK_EN
  always_ff @(posedge CS_SEQUENCER_CLOCK_50 or negedge CS_SEQUENCER_RESET_InLow) begin
    if (!CS_SEQUENCER_RESET_InLow) begin
      error_q <= 1'b0;
    end else if (fault) begin
      error_q <= 1'b1;
    end
  end
  assign bus.CS_SEQUENCER_ERROR_OutHigh = error_q;
`else
  assign bus.CS_SEQUENCER_ERROR_OutHigh = 1'b0;
`endif

  assign bus.CS_SEQUENCER_CSAddress_OutBus = addr;
  assign bus.CS_SEQUENCER_uPC_OutBus       = upc_q;
  assign bus.CS_SEQUENCER_ACK_OutHigh      = ack;
  assign bus.CS_SEQUENCER_MEMREQ_OutHigh   = memreq;
  assign bus.CS_SEQUENCER_HALT_OutHigh     = (state_q == ST_HALT);

endmodule

// File: tb/tb_cs_sequencer.sv
// Randomized and directed bench for cs_sequencer against a queue-based reference model;
// builds with or without CS_SEQUENCER_STACK_EN.
module tb_cs_sequencer;
  localparam int unsigned W  = 11;
  localparam int unsigned OW = 8;
  localparam int unsigned D  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  cs_sequencer_if #(.CSAI_DATAWIDTH(W), .OPCODE_WIDTH(OW)) bus ();

  cs_sequencer #(
    .CSAI_DATAWIDTH (W),
    .OPCODE_WIDTH   (OW),
    .STACK_DEPTH    (D)
  ) dut (
    .CS_SEQUENCER_CLOCK_50    (clk),
    .CS_SEQUENCER_RESET_InLow (rst_n),
    .bus                      (bus.master)
  );

  always #5 clk = ~clk;

  // Control-store address incrementer: registered CSAddress+1 while ACK is high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.CS_SEQUENCER_CSAI_InBus <= '0;
    else if (bus.CS_SEQUENCER_ACK_OutHigh)
      bus.CS_SEQUENCER_CSAI_InBus <= bus.CS_SEQUENCER_CSAddress_OutBus + 11'd1;
  end

  // Reference model: micro-PC, phase flags and a queue standing in for the stack.
  logic [W-1:0] m_upc;
  bit           m_boot, m_wait, m_halt, m_err;
  logic [W-1:0] m_stk[$];
  logic [W-1:0] e_addr;
  bit           e_ack, e_mreq, nx_wait, nx_halt, nx_err, nx_push, nx_pop;
  logic [25:0]  exp_vec, act_vec;

  function automatic logic [25:0] actual();
    return {bus.CS_SEQUENCER_CSAddress_OutBus, bus.CS_SEQUENCER_uPC_OutBus,
            bus.CS_SEQUENCER_ACK_OutHigh, bus.CS_SEQUENCER_MEMREQ_OutHigh,
            bus.CS_SEQUENCER_ERROR_OutHigh, bus.CS_SEQUENCER_HALT_OutHigh};
  endfunction

  task automatic model_reset();
    m_upc = '0; m_boot = 1; m_wait = 0; m_halt = 0; m_err = 0;
    m_stk.delete();
  endtask

  task automatic drive(input logic [2:0] s, input logic [W-1:0] j, input logic [OW-1:0] op,
                       input bit z, input bit n, input bit ma);
    logic [W-1:0] inc;
    bit f;
    bus.CS_SEQUENCER_SEL_InBus = s;    bus.CS_SEQUENCER_JADDR_InBus = j;
    bus.CS_SEQUENCER_OPCODE_InBus = op; bus.CS_SEQUENCER_Z_InHigh = z;
    bus.CS_SEQUENCER_N_InHigh = n;     bus.CS_SEQUENCER_MEMACK_InHigh = ma;
    inc = m_upc + 11'd1;
    f = 0;
    e_ack = 1; e_mreq = 0; nx_wait = 0; nx_halt = m_halt; nx_err = m_err;
    nx_push = 0; nx_pop = 0;
    if (m_halt) begin
      e_addr = m_upc; e_ack = 0;
    end else if (m_boot) begin
      e_addr = '0;
    end else if (m_wait) begin
      e_mreq = 1; e_addr = ma ? inc : m_upc; nx_wait = !ma;
    end else begin
      case (s)
        3'd0: e_addr = inc;
        3'd1: e_addr = j;
        3'd2: e_addr = z ? j : inc;
        3'd3: e_addr = n ? j : inc;
        3'd4: e_addr = W'(32'(op) * 4);
`ifdef CS_SEQUENCER_STACK_EN
        3'd5: if (m_stk.size() == D) f = 1; else begin nx_push = 1; e_addr = j; end
        3'd6: if (m_stk.size() == 0) f = 1; else begin nx_pop = 1; e_addr = m_stk[$]; end
`else
        3'd5: e_addr = j;
        3'd6: e_addr = inc;
`endif
        default: begin e_mreq = 1; e_addr = ma ? inc : m_upc; nx_wait = !ma; end
      endcase
      if (f) begin e_addr = m_upc; nx_halt = 1; nx_err = 1; end
    end
    exp_vec = {e_addr, m_upc, e_ack, e_mreq, m_err, m_halt};
  endtask

  task automatic advance();
    @(posedge clk); #1;
    if (nx_push) m_stk.push_back(m_upc + 11'd1);
    if (nx_pop) void'(m_stk.pop_back());
    m_upc = e_addr; m_boot = 0; m_wait = nx_wait; m_halt = nx_halt; m_err = nx_err;
  endtask

  task automatic do_reset();
    rst_n = 0; model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    drive(3'd0, '0, '0, 0, 0, 0);
    #3;
    act_vec = actual(); checks++;
    if (act_vec !== exp_vec) $display("FAIL reset_hold: got %h want %h", act_vec, exp_vec);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      drive(3'd0, 11'(i * 77), 8'(i), 0, 0, 0); #2;
      act_vec = actual(); checks++;
      if (act_vec !== exp_vec) $display("FAIL reset_boot cyc%0d: got %h want %h", i, act_vec, exp_vec);
      else passes++;
      advance();
    end
  endtask

  task automatic test_branch();
    logic [2:0] s [6] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd3};
    logic [W-1:0] j [6] = '{11'h005, 11'h040, 11'h005, 11'h040, 11'h005, 11'h3ff};
    bit zf [6] = '{0, 1, 0, 0, 0, 0};
    bit nf [6] = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      drive(s[i], j[i], 8'h00, zf[i], nf[i], 0); #2;
      act_vec = actual(); checks++;
      if (act_vec !== exp_vec) $display("FAIL branch step%0d: got %h want %h", i, act_vec, exp_vec);
      else passes++;
      advance();
    end
    for (int i = 0; i < 20; i++) begin
      drive(3'(2 + $urandom_range(0, 1)), 11'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0); #2;
      act_vec = actual(); checks++;
      if (act_vec !== exp_vec) $display("FAIL branch_rand%0d: got %h want %h", i, act_vec, exp_vec);
      else passes++;
      advance();
    end
  endtask

  task automatic test_decode();
    for (int i = 0; i < 12; i++) begin
      logic [OW-1:0] op;
      op = (i == 0) ? 8'h13 : (i == 1) ? 8'hff : (i == 2) ? 8'h00 : 8'($urandom);
      drive(3'd4, 11'($urandom), op, 0, 0, 0); #2;
      act_vec = actual(); checks++;
      if (act_vec !== exp_vec) $display("FAIL decode op%h: got %h want %h", op, act_vec, exp_vec);
      else passes++;
      advance();
    end
  endtask

  task automatic test_memwait();
    logic [2:0] s [6] = '{3'd1, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
    bit ma [6] = '{0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      drive(s[i], 11'h008, 8'h00, 0, 0, ma[i]); #2;
      act_vec = actual(); checks++;
      if (act_vec !== exp_vec) $display("FAIL memwait step%0d: got %h want %h", i, act_vec, exp_vec);
      else passes++;
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(3'($urandom), 11'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0)); #2;
      act_vec = actual(); checks++;
      if (act_vec !== exp_vec) $display("FAIL random cyc%0d: got %h want %h", i, act_vec, exp_vec);
      else passes++;
      advance();
    end
  endtask

  task automatic test_stack();
    logic [2:0] s [12] = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0, 3'd6, 3'd0};
    logic [W-1:0] j [12] = '{11'h000, 11'h010, 11'h100, 11'h000, 11'h200, 11'h210, 11'h220,
                             11'h230, 11'h240, 11'h000, 11'h000, 11'h000};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(s[i], j[i], 8'h00, 0, 0, 0); #2;
      act_vec = actual(); checks++;
      if (act_vec !== exp_vec) $display("FAIL stack step%0d: got %h want %h", i, act_vec, exp_vec);
      else passes++;
      advance();
    end
    // RET against an empty stack from a fresh start.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive((i == 1) ? 3'd6 : 3'd0, 11'h055, 8'h00, 0, 0, 0); #2;
      act_vec = actual(); checks++;
      if (act_vec !== exp_vec) $display("FAIL underflow step%0d: got %h want %h", i, act_vec, exp_vec);
      else passes++;
      advance();
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    drive(3'd0, '0, '0, 0, 0, 0); advance();
    drive(3'd1, 11'h008, '0, 0, 0, 0); advance();
    drive(3'd7, '0, '0, 0, 0, 0); advance();
    drive(3'd7, '0, '0, 0, 0, 0); #2;
    rst_n = 0; model_reset(); #1;
    exp_vec = {11'h000, 11'h000, 1'b1, 1'b0, 1'b0, 1'b0};
    act_vec = actual(); checks++;
    if (act_vec !== exp_vec) $display("FAIL reset_in_wait: got %h want %h", act_vec, exp_vec);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      drive(3'd0, '0, '0, 0, 0, 1); #2;
      act_vec = actual(); checks++;
      if (act_vec !== exp_vec) $display("FAIL rewait_boot cyc%0d: got %h want %h", i, act_vec, exp_vec);
      else passes++;
      advance();
    end
  endtask

  initial begin
    bus.CS_SEQUENCER_SEL_InBus = '0; bus.CS_SEQUENCER_JADDR_InBus = '0;
    bus.CS_SEQUENCER_OPCODE_InBus = '0; bus.CS_SEQUENCER_Z_InHigh = 0;
    bus.CS_SEQUENCER_N_InHigh = 0; bus.CS_SEQUENCER_MEMACK_InHigh = 0;
    #1;
    test_reset();
    test_branch();
    test_decode();
    test_memwait();
    test_random();
    test_stack();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
